// File: rtl/cpu_mem_pkg.sv
// -----------------------------------------------------------------------------
// cpu_mem_pkg
// Shared definitions for the MEM-stage access controller:
//   - ByteOrWord access-size encodings (2'b11 is handled as a word access)
//   - FSM state encoding
//   - byte-enable strobe constants
//   - helpers to normalise the access size and detect misaligned accesses
// -----------------------------------------------------------------------------
package cpu_mem_pkg;

  localparam logic [1:0] BW_BYTE = 2'b00;
  localparam logic [1:0] BW_HALF = 2'b01;
  localparam logic [1:0] BW_WORD = 2'b10;

  localparam logic [3:0] STRB_BYTE0   = 4'b0001;
  localparam logic [3:0] STRB_HALF_LO = 4'b0011;
  localparam logic [3:0] STRB_HALF_HI = 4'b1100;
  localparam logic [3:0] STRB_ALL     = 4'b1111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Fold the unused 2'b11 encoding onto a word access.
  function automatic logic [1:0] norm_bw(input logic [1:0] bw);
    return (bw == BW_BYTE || bw == BW_HALF) ? bw : BW_WORD;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] bw, input logic [1:0] addr_lo);
    logic [1:0] nbw;
    nbw = norm_bw(bw);
    if (nbw == BW_BYTE)      return 1'b0;
    else if (nbw == BW_HALF) return addr_lo[0];
    else                     return (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Purely combinational byte-lane steering for the MEM stage.
//   Store side: st_bw/st_addr_lo/st_data -> st_strb (byte enables) and
//               st_wdata (store data replicated onto every lane it may occupy).
//   Load side:  ld_bw/ld_addr_lo/ld_raw  -> ld_data (selected lane,
//               sign-extended to 32 bits).
// -----------------------------------------------------------------------------
module mem_lane_align
  import cpu_mem_pkg::*;
(
  input  logic [1:0]  st_bw,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_strb,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_bw,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    st_strb  = STRB_ALL;
    st_wdata = st_data;
    case (norm_bw(st_bw))
      BW_BYTE: begin
        st_strb  = STRB_BYTE0 << st_addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      BW_HALF: begin
        st_strb  = st_addr_lo[1] ? STRB_HALF_HI : STRB_HALF_LO;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = ld_raw[{ld_addr_lo, 3'b000} +: 8];
    ld_half = ld_addr_lo[1] ? ld_raw[31:16] : ld_raw[15:0];
    ld_data = ld_raw;
    case (norm_bw(ld_bw))
      BW_BYTE: ld_data = {{24{ld_byte[7]}}, ld_byte};
      BW_HALF: ld_data = {{16{ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// MEM-stage access controller. Takes the EX/MEM register outputs, runs one
// req/ack bus transaction to data RAM or IO per load/store, stalls the
// earlier pipe stages until the transaction completes, and registers the
// result into the MEM/WB boundary.
//
// Reset: rst_n is a synchronous ACTIVE-HIGH reset (reset while rst_n == 1).
//
// Ports
//   EX/MEM in : RegWrite_i, MemRead_i, MemWrite_i, IoRead_i, IoWrite_i,
//               MemOrIoToReg_i, ByteOrWord_i[1:0], ALUResult_i[31:0],
//               rdata2_i[31:0], rd_i[4:0]
//   stall_o   : combinational; holds EX/MEM and earlier stages
//   bus       : mem_req_o, mem_we_o, io_sel_o, mem_addr_o[ADDR_W-1:0],
//               mem_wstrb_o[3:0], mem_wdata_o[31:0] out;
//               mem_rdata_i[31:0], mem_ack_i in
//   MEM/WB out: RegWrite_o, MemOrIoToReg_o, rd_o, ALUResult_o, ReadData_o
//   events    : misalign_o (access dropped), bus_err_o (ack timeout),
//               both single-cycle pulses
// -----------------------------------------------------------------------------
module mem_access_stage
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              IoRead_i,
  input  logic              IoWrite_i,
  input  logic              MemOrIoToReg_i,
  input  logic [1:0]        ByteOrWord_i,
  input  logic [31:0]       ALUResult_i,
  input  logic [31:0]       rdata2_i,
  input  logic [4:0]        rd_i,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic              io_sel_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_wstrb_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              RegWrite_o,
  output logic              MemOrIoToReg_o,
  output logic [4:0]        rd_o,
  output logic [31:0]       ALUResult_o,
  output logic [31:0]       ReadData_o,
  output logic              misalign_o,
  output logic              bus_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  logic op, wr, io, mis, busy, timeout;
  logic start, finish_ok, finish_err;

  // Copies of the accepted instruction, held for the whole transaction.
  logic [1:0]  bw_q, alo_q;
  logic        rw_q, m2r_q;
  logic [4:0]  rd_q;
  logic [31:0] alu_q;

  logic [3:0]  st_strb;
  logic [31:0] st_wdata, ld_data;

  assign op      = MemRead_i | MemWrite_i | IoRead_i | IoWrite_i;
  // A write request overrides a simultaneous read request.
  assign wr      = MemWrite_i | IoWrite_i;
  assign io      = wr ? IoWrite_i : IoRead_i;
  assign mis     = op & is_misaligned(ByteOrWord_i, ALUResult_i[1:0]);
  assign busy    = (state_q == ST_BUSY);
  assign timeout = busy & (cnt_q == CNT_W'(TIMEOUT - 1));

  // Stall drops in the completion cycle so EX/MEM advances on that edge.
  assign stall_o   = op & ~mis & ~(busy & (mem_ack_i | timeout));
  assign mem_req_o = busy;

  mem_lane_align u_align (
    .st_bw      (ByteOrWord_i),
    .st_addr_lo (ALUResult_i[1:0]),
    .st_data    (rdata2_i),
    .st_strb    (st_strb),
    .st_wdata   (st_wdata),
    .ld_bw      (bw_q),
    .ld_addr_lo (alo_q),
    .ld_raw     (mem_rdata_i),
    .ld_data    (ld_data)
  );

  // Next-state logic. Ack takes priority over a same-cycle timeout.
  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    finish_ok  = 1'b0;
    finish_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op && !mis) begin
          state_d = ST_BUSY;
          start   = 1'b1;
        end
      end
      ST_BUSY: begin
        if (mem_ack_i) begin
          state_d   = ST_IDLE;
          finish_ok = 1'b1;
        end else if (timeout) begin
          state_d    = ST_IDLE;
          finish_err = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: clocked state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (busy && state_d == ST_BUSY) ? cnt_q + 1'b1 : '0;
    end
  end

  // Request latches: captured once on the accepting edge so the bus sees
  // stable address/data for the whole transaction.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      mem_addr_o  <= '0;
      mem_we_o    <= 1'b0;
      io_sel_o    <= 1'b0;
      mem_wstrb_o <= '0;
      mem_wdata_o <= '0;
      bw_q        <= '0;
      alo_q       <= '0;
      rw_q        <= 1'b0;
      m2r_q       <= 1'b0;
      rd_q        <= '0;
      alu_q       <= '0;
    end else if (start) begin
      mem_addr_o  <= ALUResult_i[ADDR_W+1:2];
      mem_we_o    <= wr;
      io_sel_o    <= io;
      mem_wstrb_o <= st_strb;
      mem_wdata_o <= st_wdata;
      bw_q        <= ByteOrWord_i;
      alo_q       <= ALUResult_i[1:0];
      rw_q        <= RegWrite_i;
      m2r_q       <= MemOrIoToReg_i;
      rd_q        <= rd_i;
      alu_q       <= ALUResult_i;
    end
  end

  // MEM/WB boundary. Any edge that neither passes a non-memory instruction
  // through nor completes a transaction inserts a bubble.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      RegWrite_o     <= 1'b0;
      MemOrIoToReg_o <= 1'b0;
      rd_o           <= '0;
      ALUResult_o    <= '0;
      ReadData_o     <= '0;
      misalign_o     <= 1'b0;
      bus_err_o      <= 1'b0;
    end else begin
      misalign_o     <= ~busy & mis;
      bus_err_o      <= finish_err;
      RegWrite_o     <= 1'b0;
      MemOrIoToReg_o <= 1'b0;
      rd_o           <= '0;
      ALUResult_o    <= '0;
      ReadData_o     <= '0;
      if (!busy && !op) begin
        RegWrite_o     <= RegWrite_i;
        MemOrIoToReg_o <= MemOrIoToReg_i;
        rd_o           <= rd_i;
        ALUResult_o    <= ALUResult_i;
      end else if (finish_ok) begin
        RegWrite_o     <= rw_q;
        MemOrIoToReg_o <= m2r_q;
        rd_o           <= rd_q;
        ALUResult_o    <= alu_q;
        ReadData_o     <= mem_we_o ? '0 : ld_data;
      end
    end
  end

endmodule
